// File: rtl/arm_mem_arbiter.sv
// Round-robin arbiter sharing one memory handshake port between fetch (port 0) and data (port 1).
// Optional wait-state timeout is enabled by defining ARB_TIMEOUT_EN.
module arm_mem_arbiter #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          MFA0,
    input  logic          MFA1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic          WB0,
    input  logic          WB1,
    input  logic [AW-1:0] ADD0,
    input  logic [AW-1:0] ADD1,
    input  logic [DW-1:0] DIN0,
    input  logic [DW-1:0] DIN1,
    output logic          MFC0,
    output logic          MFC1,
    output logic          ERR0,
    output logic          ERR1,
    output logic [DW-1:0] DOUT0,
    output logic [DW-1:0] DOUT1,
    output logic          MEM_MFA,
    output logic          MEM_RW,
    output logic          MEM_WB,
    output logic [AW-1:0] MEM_ADD,
    output logic [DW-1:0] MEM_DOUT,
    input  logic [DW-1:0] MEM_DIN,
    input  logic          MEM_MFC
);

    if (AW < 2 || DW <= 8 || TIMEOUT < 1) begin : g_param_check
        $error("arm_mem_arbiter: requires AW >= 2, DW > 8, TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RELEASE} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_grant, w_grant_nxt;
    logic          r_last, w_last_nxt;
    logic          r_err, w_err_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_wb, w_wb_nxt;
    logic [AW-1:0] r_add, w_add_nxt;
    logic [DW-1:0] r_wdat, w_wdat_nxt;
    logic          r_mem_mfa, w_mem_mfa_nxt;
    logic          r_mfc0, w_mfc0_nxt;
    logic          r_mfc1, w_mfc1_nxt;
    logic          r_err0, w_err0_nxt;
    logic          r_err1, w_err1_nxt;
    logic [DW-1:0] r_dout0, w_dout0_nxt;
    logic [DW-1:0] r_dout1, w_dout1_nxt;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
`endif

    // Tie goes to the port that was not served last
    logic          w_sel;
    logic          w_sel_rw;
    logic          w_sel_wb;
    logic [AW-1:0] w_sel_add;
    logic [DW-1:0] w_sel_din;
    logic          w_misalign;
    logic          w_served_req;
    logic [DW-1:0] w_rdata;

    assign w_sel        = (MFA0 && MFA1) ? ~r_last : MFA1;
    assign w_sel_rw     = w_sel ? RW1 : RW0;
    assign w_sel_wb     = w_sel ? WB1 : WB0;
    assign w_sel_add    = w_sel ? ADD1 : ADD0;
    assign w_sel_din    = w_sel ? DIN1 : DIN0;
    assign w_misalign   = w_sel_wb && (w_sel_add[1:0] != 2'b00);
    assign w_served_req = r_grant ? MFA1 : MFA0;
    assign w_rdata      = r_wb ? MEM_DIN : {{(DW-8){1'b0}}, MEM_DIN[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        w_rw_nxt    = r_rw;
        w_wb_nxt    = r_wb;
        w_add_nxt   = r_add;
        w_wdat_nxt  = r_wdat;
        w_dout0_nxt = r_dout0;
        w_dout1_nxt = r_dout1;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (MFA0 || MFA1) begin
                    w_grant_nxt = w_sel;
                    w_rw_nxt    = w_sel_rw;
                    w_wb_nxt    = w_sel_wb;
                    w_add_nxt   = w_sel_add;
                    w_wdat_nxt  = w_sel_din;
                    w_err_nxt   = w_misalign;
                    w_state_nxt = w_misalign ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
`ifdef ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            WAIT: begin
                if (MEM_MFC) begin
                    if (r_rw && r_grant) w_dout1_nxt = w_rdata;
                    if (r_rw && !r_grant) w_dout0_nxt = w_rdata;
                    w_state_nxt = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
`endif
            end
            DONE: begin
                w_last_nxt  = r_grant;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!w_served_req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_mem_mfa_nxt = (w_state_nxt == WAIT);
        w_mfc0_nxt    = (r_state == DONE) && !r_grant;
        w_mfc1_nxt    = (r_state == DONE) && r_grant;
        w_err0_nxt    = (r_state == DONE) && !r_grant && r_err;
        w_err1_nxt    = (r_state == DONE) && r_grant && r_err;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_err     <= 1'b0;
            r_rw      <= 1'b0;
            r_wb      <= 1'b0;
            r_add     <= '0;
            r_wdat    <= '0;
            r_mem_mfa <= 1'b0;
            r_mfc0    <= 1'b0;
            r_mfc1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_dout0   <= '0;
            r_dout1   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_err     <= w_err_nxt;
            r_rw      <= w_rw_nxt;
            r_wb      <= w_wb_nxt;
            r_add     <= w_add_nxt;
            r_wdat    <= w_wdat_nxt;
            r_mem_mfa <= w_mem_mfa_nxt;
            r_mfc0    <= w_mfc0_nxt;
            r_mfc1    <= w_mfc1_nxt;
            r_err0    <= w_err0_nxt;
            r_err1    <= w_err1_nxt;
            r_dout0   <= w_dout0_nxt;
            r_dout1   <= w_dout1_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
`endif
        end
    end

    assign MEM_MFA  = r_mem_mfa;
    assign MEM_RW   = r_rw;
    assign MEM_WB   = r_wb;
    assign MEM_ADD  = r_add;
    assign MEM_DOUT = r_wdat;
    assign MFC0     = r_mfc0;
    assign MFC1     = r_mfc1;
    assign ERR0     = r_err0;
    assign ERR1     = r_err1;
    assign DOUT0    = r_dout0;
    assign DOUT1    = r_dout1;

endmodule
